// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for a 5-stage pipeline
//
// Drives the enable and flush controls of the PC and pipeline registers.
// It also runs the data memory handshake with a timeout, detects load-use
// hazards, squashes wrong-path instructions and counts stall cycles.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   mem_op_MEM, dmem_ack     MEM-stage access request / memory completion
//   Mem2Reg_EX, waddr_EX     EX-stage load flag and destination register
//   rs1_ID, rs2_ID           ID-stage source registers
//   rs1_used_ID, rs2_used_ID ID-stage source register usage flags
//   branch_taken_EX          taken branch or jump resolved in EX
//   EN_*                     pipeline register enables
//   flush_IF_ID, flush_ID_EX bubble insertion controls
//   dmem_req                 data memory request
//   mem_err                  sticky memory timeout error
//   stall_cycles             saturating count of cycles with the PC frozen
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_op_MEM,
    input  logic        dmem_ack,
    input  logic        Mem2Reg_EX,
    input  logic [4:0]  waddr_EX,
    input  logic [4:0]  rs1_ID,
    input  logic [4:0]  rs2_ID,
    input  logic        rs1_used_ID,
    input  logic        rs2_used_ID,
    input  logic        branch_taken_EX,
    output logic        EN_PC,
    output logic        EN_IF_ID,
    output logic        EN_ID_EX,
    output logic        EN_EX_MEM,
    output logic        EN_MEM_WB,
    output logic        flush_IF_ID,
    output logic        flush_ID_EX,
    output logic        dmem_req,
    output logic        mem_err,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               pipe_go;
    logic               load_use;

    assign load_use = Mem2Reg_EX && (waddr_EX != 5'd0) &&
                      ((rs1_used_ID && (rs1_ID == waddr_EX)) ||
                       (rs2_used_ID && (rs2_ID == waddr_EX)));

    always_comb begin
        next_state  = state;
        pipe_go     = 1'b0;
        EN_PC       = 1'b0;
        EN_IF_ID    = 1'b0;
        EN_ID_EX    = 1'b0;
        EN_EX_MEM   = 1'b0;
        EN_MEM_WB   = 1'b0;
        flush_IF_ID = 1'b0;
        flush_ID_EX = 1'b0;
        dmem_req    = 1'b0;

        case (state)
            S_RUN: begin
                dmem_req = mem_op_MEM;
                if (mem_op_MEM && !dmem_ack) begin
                    next_state = S_WAIT;
                end else begin
                    pipe_go = 1'b1;
                end
            end
            S_WAIT: begin
                dmem_req = 1'b1;
                // A completing ack wins over an expiring timeout.
                if (dmem_ack) begin
                    pipe_go    = 1'b1;
                    next_state = S_RUN;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    next_state = S_ERR;
                end
            end
            default: begin
                next_state = S_ERR;
            end
        endcase

        // Pipeline advances: branch squash outranks load-use, since the
        // ID-stage instruction is wrong-path once a branch is taken.
        if (pipe_go) begin
            EN_PC     = 1'b1;
            EN_IF_ID  = 1'b1;
            EN_ID_EX  = 1'b1;
            EN_EX_MEM = 1'b1;
            EN_MEM_WB = 1'b1;
            if (branch_taken_EX) begin
                flush_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
            end else if (load_use) begin
                EN_PC       = 1'b0;
                EN_IF_ID    = 1'b0;
                flush_ID_EX = 1'b1;
            end
        end

        // Reset forces all controls low without waiting for a clock.
        if (rst) begin
            EN_PC       = 1'b0;
            EN_IF_ID    = 1'b0;
            EN_ID_EX    = 1'b0;
            EN_EX_MEM   = 1'b0;
            EN_MEM_WB   = 1'b0;
            flush_IF_ID = 1'b0;
            flush_ID_EX = 1'b0;
            dmem_req    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_RUN;
            wait_cnt     <= '0;
            mem_err      <= 1'b0;
            stall_cycles <= 16'd0;
        end else begin
            state <= next_state;
            if (state == S_WAIT && !dmem_ack) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (next_state == S_ERR) begin
                mem_err <= 1'b1;
            end
            if (!EN_PC && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_op_MEM, dmem_ack, Mem2Reg_EX;
    logic [4:0]  waddr_EX, rs1_ID, rs2_ID;
    logic        rs1_used_ID, rs2_used_ID, branch_taken_EX;
    logic        EN_PC, EN_IF_ID, EN_ID_EX, EN_EX_MEM, EN_MEM_WB;
    logic        flush_IF_ID, flush_ID_EX, dmem_req, mem_err;
    logic [15:0] stall_cycles;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .mem_op_MEM(mem_op_MEM), .dmem_ack(dmem_ack), .Mem2Reg_EX(Mem2Reg_EX),
        .waddr_EX(waddr_EX), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .branch_taken_EX(branch_taken_EX),
        .EN_PC(EN_PC), .EN_IF_ID(EN_IF_ID), .EN_ID_EX(EN_ID_EX),
        .EN_EX_MEM(EN_EX_MEM), .EN_MEM_WB(EN_MEM_WB),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
        .dmem_req(dmem_req), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    wire [4:0] en = {EN_PC, EN_IF_ID, EN_ID_EX, EN_EX_MEM, EN_MEM_WB};
    wire [1:0] fl = {flush_IF_ID, flush_ID_EX};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check all combinational controls at once.
    task automatic chk_ctl(input string tag, input logic [4:0] e_en,
                           input logic [1:0] e_fl, input logic e_req);
        #1;
        chk({tag, "_en"}, 16'(en), 16'(e_en));
        chk({tag, "_fl"}, 16'(fl), 16'(e_fl));
        chk({tag, "_req"}, 16'(dmem_req), 16'(e_req));
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_in;
        mem_op_MEM = 0; dmem_ack = 0; Mem2Reg_EX = 0; waddr_EX = 0;
        rs1_ID = 0; rs2_ID = 0; rs1_used_ID = 0; rs2_used_ID = 0;
        branch_taken_EX = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_in();
        mem_op_MEM = 1;
        // Reset state: all controls forced low even with a pending access.
        chk_ctl("reset", 5'b00000, 2'b00, 1'b0);
        chk("reset_err", 16'(mem_err), 16'd0);
        chk("reset_stall", stall_cycles, 16'd0);
        tick();
        rst = 1'b0;
        mem_op_MEM = 0;
        chk_ctl("idle", 5'b11111, 2'b00, 1'b0);

        // Zero-wait access.
        mem_op_MEM = 1; dmem_ack = 1;
        chk_ctl("zero_wait", 5'b11111, 2'b00, 1'b1);
        tick();
        clear_in();
        chk_ctl("zero_wait_run", 5'b11111, 2'b00, 1'b0);
        chk("zero_wait_stall", stall_cycles, 16'd0);

        // Three-cycle memory access, ack on the fourth cycle.
        mem_op_MEM = 1;
        chk_ctl("mem3_c1", 5'b00000, 2'b00, 1'b1);
        tick();
        chk_ctl("mem3_c2", 5'b00000, 2'b00, 1'b1);
        tick();
        chk_ctl("mem3_c3", 5'b00000, 2'b00, 1'b1);
        tick();
        dmem_ack = 1;
        chk_ctl("mem3_c4", 5'b11111, 2'b00, 1'b1);
        tick();
        clear_in();
        chk_ctl("mem3_run", 5'b11111, 2'b00, 1'b0);
        chk("mem3_stall", stall_cycles, 16'd3);

        // Load-use on rs2.
        Mem2Reg_EX = 1; waddr_EX = 5; rs2_ID = 5; rs2_used_ID = 1;
        chk_ctl("lu_rs2", 5'b00111, 2'b01, 1'b0);
        tick();
        chk("lu_rs2_stall", stall_cycles, 16'd4);
        waddr_EX = 0; rs2_ID = 0;
        chk_ctl("lu_x0", 5'b11111, 2'b00, 1'b0);
        clear_in();
        Mem2Reg_EX = 1; waddr_EX = 7; rs1_ID = 7; rs1_used_ID = 1;
        chk_ctl("lu_rs1", 5'b00111, 2'b01, 1'b0);
        tick();
        rs1_used_ID = 0;
        chk_ctl("lu_rs1_unused", 5'b11111, 2'b00, 1'b0);
        chk("lu_rs1_stall", stall_cycles, 16'd5);

        // Branch coincident with load-use: branch action only.
        clear_in();
        Mem2Reg_EX = 1; waddr_EX = 5; rs2_ID = 5; rs2_used_ID = 1; branch_taken_EX = 1;
        chk_ctl("br_lu", 5'b11111, 2'b11, 1'b0);
        tick();
        chk("br_lu_stall", stall_cycles, 16'd5);

        // Branch during a memory freeze flushes only on the ack cycle.
        clear_in();
        mem_op_MEM = 1; branch_taken_EX = 1;
        chk_ctl("br_wait_a", 5'b00000, 2'b00, 1'b1);
        tick();
        chk_ctl("br_wait_b", 5'b00000, 2'b00, 1'b1);
        tick();
        dmem_ack = 1;
        chk_ctl("br_wait_ack", 5'b11111, 2'b11, 1'b1);
        tick();
        clear_in();
        chk("br_wait_stall", stall_cycles, 16'd7);

        // Ack on the last tolerated WAIT cycle.
        mem_op_MEM = 1;
        tick();
        repeat (14) tick();
        dmem_ack = 1;
        chk_ctl("last_ack", 5'b11111, 2'b00, 1'b1);
        tick();
        clear_in();
        chk_ctl("last_ack_run", 5'b11111, 2'b00, 1'b0);
        chk("last_ack_err", 16'(mem_err), 16'd0);
        chk("last_ack_stall", stall_cycles, 16'd22);

        // Timeout: 1 RUN freeze + 15 WAIT cycles, then ERR.
        mem_op_MEM = 1;
        repeat (15) tick();
        chk_ctl("pre_timeout", 5'b00000, 2'b00, 1'b1);
        chk("pre_timeout_err", 16'(mem_err), 16'd0);
        tick();
        chk_ctl("err", 5'b00000, 2'b00, 1'b0);
        chk("err_flag", 16'(mem_err), 16'd1);
        dmem_ack = 1;
        chk_ctl("err_ack_ignored", 5'b00000, 2'b00, 1'b0);
        tick();
        chk("err_hold", 16'(mem_err), 16'd1);
        chk("err_stall", stall_cycles, 16'd39);

        // Asynchronous reset clears state mid-cycle.
        rst = 1'b1;
        #1;
        chk("async_err", 16'(mem_err), 16'd0);
        chk("async_stall", stall_cycles, 16'd0);
        tick();
        rst = 1'b0;
        clear_in();
        chk_ctl("after_err_rst", 5'b11111, 2'b00, 1'b0);

        // Reset during WAIT drops dmem_req at once and restarts in RUN.
        mem_op_MEM = 1;
        tick();
        chk_ctl("wait_pre_rst", 5'b00000, 2'b00, 1'b1);
        rst = 1'b1;
        chk_ctl("wait_rst_req", 5'b00000, 2'b00, 1'b0);
        tick();
        rst = 1'b0;
        mem_op_MEM = 0;
        chk_ctl("wait_rst_run", 5'b11111, 2'b00, 1'b0);

        // Saturation: time out into ERR and stay there.
        mem_op_MEM = 1;
        repeat (16) tick();
        repeat (70000) tick();
        chk("stall_sat", stall_cycles, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
